// File: rtl/rb_pkg.sv
// -----------------------------------------------------------------------------
// rb_pkg
// Shared types and helpers for the parametrised register bank.
//   rb_mode_t   : access mode of one register (RW, RO status, W1C sticky, PULSE)
//   mode_of()   : resolves overlapping mode masks, RO > W1C > PULSE > RW
//   RB_MAX_REGS : largest supported register count (mask vectors are this wide)
// -----------------------------------------------------------------------------
package rb_pkg;

    localparam int unsigned RB_MAX_REGS = 64;

    typedef enum logic [1:0] {
        RB_RW    = 2'd0,
        RB_RO    = 2'd1,
        RB_W1C   = 2'd2,
        RB_PULSE = 2'd3
    } rb_mode_t;

    // Masks are zero-extended to RB_MAX_REGS bits by the caller.
    function automatic rb_mode_t mode_of(
        input logic [5:0]             idx,
        input logic [RB_MAX_REGS-1:0] ro_mask,
        input logic [RB_MAX_REGS-1:0] w1c_mask,
        input logic [RB_MAX_REGS-1:0] pulse_mask
    );
        rb_mode_t mode;
        if (ro_mask[idx]) begin
            mode = RB_RO;
        end else if (w1c_mask[idx]) begin
            mode = RB_W1C;
        end else if (pulse_mask[idx]) begin
            mode = RB_PULSE;
        end else begin
            mode = RB_RW;
        end
        return mode;
    endfunction

endpackage

// File: rtl/rb_sticky_field.sv
// -----------------------------------------------------------------------------
// rb_sticky_field
// W-bit write-1-to-clear sticky storage. A set and a clear on the same bit in
// the same cycle leaves the bit set, so no event is ever lost.
//   clk, reset : clock, synchronous active-high reset (clears storage)
//   set_in     : per-bit event pulses
//   clr_in     : per-bit clear request (write data already qualified by a hit)
//   value_out  : current sticky value
// -----------------------------------------------------------------------------
module rb_sticky_field
    import rb_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] set_in,
    input  logic [W-1:0] clr_in,
    output logic [W-1:0] value_out
);

    logic [W-1:0] sticky_d;
    logic [W-1:0] sticky_q;

    // Next sticky value: clear first, then OR in events so the set wins.
    always_comb begin
        sticky_d = (sticky_q & ~clr_in) | set_in;
    end

    // Sticky storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign value_out = sticky_q;

endmodule

// File: rtl/rb_param_bank.sv
// -----------------------------------------------------------------------------
// rb_param_bank
// Parametrised register bank between a serial register master and a hardware
// block. Register i sits at BASE_ADR+i; its mode comes from the masks.
// Optional build macro: RB_SHADOW_EN (shadow/active RW copies with a commit
// register at BASE_ADR+NUM_REGS).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   address        : register address (ADR_BITS <= 32)
//   data_write_in  : write data
//   reg_en         : one-cycle access strobe; write_en selects write (1)/read (0)
//   data_read_out  : registered read data, held between reads
//   rd_valid       : one-cycle pulse, read data valid (latency 1)
//   addr_err       : one-cycle pulse, previous access was out of range
//   cfg_out        : packed register values towards hardware
//   status_in      : RO sources, event_in : W1C set pulses
//   irq            : OR of all W1C bits
// -----------------------------------------------------------------------------
module rb_param_bank
    import rb_pkg::*;
#(
    parameter int unsigned                   ADR_BITS   = 8,
    parameter int unsigned                   DATA_W     = 8,
    parameter int unsigned                   NUM_REGS   = 8,
    parameter int unsigned                   BASE_ADR   = 0,
    parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VAL  = '0,
    parameter logic [NUM_REGS-1:0]           RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0]           W1C_MASK   = '0,
    parameter logic [NUM_REGS-1:0]           PULSE_MASK = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ADR_BITS-1:0]          address,
    input  logic [DATA_W-1:0]            data_write_in,
    input  logic                         reg_en,
    input  logic                         write_en,
    output logic [DATA_W-1:0]            data_read_out,
    output logic                         rd_valid,
    output logic                         addr_err,
    output logic [NUM_REGS*DATA_W-1:0]   cfg_out,
    input  logic [NUM_REGS*DATA_W-1:0]   status_in,
    input  logic [NUM_REGS*DATA_W-1:0]   event_in,
    output logic                         irq
);

    localparam logic [RB_MAX_REGS-1:0] RO_EXT    = RB_MAX_REGS'(RO_MASK);
    localparam logic [RB_MAX_REGS-1:0] W1C_EXT   = RB_MAX_REGS'(W1C_MASK);
    localparam logic [RB_MAX_REGS-1:0] PULSE_EXT = RB_MAX_REGS'(PULSE_MASK);

    logic [31:0]         idx_s;
    logic                in_regs_s;
    logic                is_commit_s;
    logic                in_range_s;
    logic                rd_req_s;
    logic                wr_req_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic [NUM_REGS-1:0] w1c_any_s;
    logic [DATA_W-1:0]   read_val_s [NUM_REGS];
    logic [DATA_W-1:0]   rd_mux_s;
`ifdef RB_SHADOW_EN
    logic                commit_s;
`endif

    logic [DATA_W-1:0]   data_read_out_d, data_read_out_q;
    logic                rd_valid_d, rd_valid_q;
    logic                addr_err_d, addr_err_q;

    // Slices not owned by an RO or W1C register are intentionally ignored.
    logic unused_s;
    assign unused_s = ^{status_in, event_in};

    // Address decode. An address below BASE_ADR wraps to a huge index and so
    // falls out of range without a separate lower-bound compare.
    always_comb begin
        idx_s     = 32'(address) - BASE_ADR;
        in_regs_s = (idx_s < NUM_REGS);
`ifdef RB_SHADOW_EN
        is_commit_s = (idx_s == NUM_REGS);
`else
        is_commit_s = 1'b0;
`endif
        in_range_s = in_regs_s | is_commit_s;
        rd_req_s   = reg_en & ~write_en;
        wr_req_s   = reg_en & write_en;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_sel_s[i] = wr_req_s & in_regs_s & (idx_s == 32'(i));
        end
`ifdef RB_SHADOW_EN
        commit_s = wr_req_s & is_commit_s & data_write_in[0];
`endif
    end

    // Read mux as an OR of one-hot selected values; commit/out-of-range give 0.
    always_comb begin
        rd_mux_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_mux_s = rd_mux_s |
                       ((in_regs_s && (idx_s == 32'(i))) ? read_val_s[i] : {DATA_W{1'b0}});
        end
    end

    // Next values of the read/response outputs.
    always_comb begin
        data_read_out_d = rd_req_s ? rd_mux_s : data_read_out_q;
        rd_valid_d      = rd_req_s;
        addr_err_d      = reg_en & ~in_range_s;
    end

    // Response output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_read_out_q <= '0;
            rd_valid_q      <= 1'b0;
            addr_err_q      <= 1'b0;
        end else begin
            data_read_out_q <= data_read_out_d;
            rd_valid_q      <= rd_valid_d;
            addr_err_q      <= addr_err_d;
        end
    end

    assign data_read_out = data_read_out_q;
    assign rd_valid      = rd_valid_q;
    assign addr_err      = addr_err_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam rb_mode_t          MODE = mode_of(6'(i), RO_EXT, W1C_EXT, PULSE_EXT);
        localparam logic [DATA_W-1:0] RST  = RESET_VAL[i*DATA_W +: DATA_W];

        if (MODE == RB_RW) begin : g_rw
            logic [DATA_W-1:0] act_d, act_q;
`ifdef RB_SHADOW_EN
            logic [DATA_W-1:0] shd_d, shd_q;

            // Shadow takes writes; a commit copies the post-write shadow.
            always_comb begin
                shd_d = wr_sel_s[i] ? data_write_in : shd_q;
                act_d = commit_s ? shd_d : act_q;
            end

            // Shadow and active copies.
            always_ff @(posedge clk) begin
                if (reset) begin
                    shd_q <= RST;
                    act_q <= RST;
                end else begin
                    shd_q <= shd_d;
                    act_q <= act_d;
                end
            end

            assign read_val_s[i] = shd_q;
`else
            // Single copy updated directly by writes.
            always_comb begin
                act_d = wr_sel_s[i] ? data_write_in : act_q;
            end

            // RW storage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    act_q <= RST;
                end else begin
                    act_q <= act_d;
                end
            end

            assign read_val_s[i] = act_q;
`endif
            assign cfg_out[i*DATA_W +: DATA_W] = act_q;
            assign w1c_any_s[i]                = 1'b0;
        end else if (MODE == RB_RO) begin : g_ro
            assign read_val_s[i]               = status_in[i*DATA_W +: DATA_W];
            assign cfg_out[i*DATA_W +: DATA_W] = '0;
            assign w1c_any_s[i]                = 1'b0;
        end else if (MODE == RB_W1C) begin : g_w1c
            logic [DATA_W-1:0] stk_s;

            rb_sticky_field #(
                .W (DATA_W)
            ) u_sticky (
                .clk       (clk),
                .reset     (reset),
                .set_in    (event_in[i*DATA_W +: DATA_W]),
                .clr_in    (wr_sel_s[i] ? data_write_in : {DATA_W{1'b0}}),
                .value_out (stk_s)
            );

            assign read_val_s[i]               = stk_s;
            assign cfg_out[i*DATA_W +: DATA_W] = stk_s;
            assign w1c_any_s[i]                = |stk_s;
        end else begin : g_pulse
            logic [DATA_W-1:0] pls_d, pls_q;

            // Pulse holds written data for one cycle only.
            always_comb begin
                pls_d = wr_sel_s[i] ? data_write_in : {DATA_W{1'b0}};
            end

            // Pulse storage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pls_q <= '0;
                end else begin
                    pls_q <= pls_d;
                end
            end

            assign read_val_s[i]               = '0;
            assign cfg_out[i*DATA_W +: DATA_W] = pls_q;
            assign w1c_any_s[i]                = 1'b0;
        end
    end

    assign irq = |w1c_any_s;

endmodule

// File: tb/tb_rb_param_bank.sv
// -----------------------------------------------------------------------------
// tb_rb_param_bank
// Self-checking bench for rb_param_bank: directed vector table, hand-written
// shadow/RW sequence, and randomized traffic against a behavioural model.
// Register map used: 0..2 RW, 3 W1C (also in PULSE mask), 4 PULSE,
// 5 RO, 6 RO (also in W1C mask), 7 PULSE.
// -----------------------------------------------------------------------------
module tb_rb_param_bank;

    localparam int          NR      = 8;
    localparam logic [63:0] RST_VAL = 64'h5A66_7788_9934_1285;
    localparam logic [7:0]  RO_M    = 8'b0110_0000;
    localparam logic [7:0]  W1C_M   = 8'b0100_1000;
    localparam logic [7:0]  PUL_M   = 8'b1001_1000;
`ifdef RB_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  address;
    logic [7:0]  data_write_in;
    logic        reg_en;
    logic        write_en;
    logic [7:0]  data_read_out;
    logic        rd_valid;
    logic        addr_err;
    logic [63:0] cfg_out;
    logic [63:0] status_in;
    logic [63:0] event_in;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rb_param_bank #(
        .ADR_BITS   (8),
        .DATA_W     (8),
        .NUM_REGS   (NR),
        .BASE_ADR   (0),
        .RESET_VAL  (RST_VAL),
        .RO_MASK    (RO_M),
        .W1C_MASK   (W1C_M),
        .PULSE_MASK (PUL_M)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .data_write_in (data_write_in),
        .reg_en        (reg_en),
        .write_en      (write_en),
        .data_read_out (data_read_out),
        .rd_valid      (rd_valid),
        .addr_err      (addr_err),
        .cfg_out       (cfg_out),
        .status_in     (status_in),
        .event_in      (event_in),
        .irq           (irq)
    );

    // ---------------- behavioural model ----------------
    // mode: 0 RW, 1 RO, 2 W1C, 3 PULSE (precedence RO > W1C > PULSE > RW)
    function automatic int tb_mode(input int i);
        if (RO_M[i])       return 1;
        else if (W1C_M[i]) return 2;
        else if (PUL_M[i]) return 3;
        else               return 0;
    endfunction

    logic [7:0] m_act [NR];
    logic [7:0] m_shd [NR];
    logic [7:0] m_stk [NR];
    logic [7:0] m_pls [NR];
    logic [7:0] m_dout;
    logic       m_rv;
    logic       m_ae;

    task automatic model_edge();
        int         a;
        bit         inr, com, wr;
        logic [7:0] clr;
        a = int'(address);
        if (reset) begin
            for (int i = 0; i < NR; i++) begin
                m_act[i] = RST_VAL[i*8 +: 8];
                m_shd[i] = RST_VAL[i*8 +: 8];
                m_stk[i] = 8'h00;
                m_pls[i] = 8'h00;
            end
            m_dout = 8'h00;
            m_rv   = 1'b0;
            m_ae   = 1'b0;
        end else begin
            inr  = (a < NR);
            com  = SHADOW && (a == NR);
            wr   = reg_en && write_en;
            m_rv = reg_en && !write_en;
            m_ae = reg_en && !inr && !com;
            if (m_rv) begin
                if (!inr) m_dout = 8'h00;
                else begin
                    case (tb_mode(a))
                        0:       m_dout = m_shd[a];
                        1:       m_dout = status_in[a*8 +: 8];
                        2:       m_dout = m_stk[a];
                        default: m_dout = 8'h00;
                    endcase
                end
            end
            for (int i = 0; i < NR; i++) begin
                m_pls[i] = 8'h00;
                if (tb_mode(i) == 2) begin
                    clr      = (wr && inr && a == i) ? data_write_in : 8'h00;
                    m_stk[i] = (m_stk[i] & ~clr) | event_in[i*8 +: 8];
                end
            end
            if (wr && inr) begin
                if (tb_mode(a) == 0) begin
                    m_shd[a] = data_write_in;
                    if (!SHADOW) m_act[a] = data_write_in;
                end else if (tb_mode(a) == 3) begin
                    m_pls[a] = data_write_in;
                end
            end
            if (wr && com && data_write_in[0]) begin
                for (int i = 0; i < NR; i++)
                    if (tb_mode(i) == 0) m_act[i] = m_shd[i];
            end
        end
    endtask

    function automatic logic [63:0] exp_cfg();
        logic [63:0] v;
        v = 64'h0;
        for (int i = 0; i < NR; i++) begin
            case (tb_mode(i))
                0:       v[i*8 +: 8] = m_act[i];
                2:       v[i*8 +: 8] = m_stk[i];
                3:       v[i*8 +: 8] = m_pls[i];
                default: v[i*8 +: 8] = 8'h00;
            endcase
        end
        return v;
    endfunction

    function automatic logic exp_irq();
        logic r;
        r = 1'b0;
        for (int i = 0; i < NR; i++)
            if (tb_mode(i) == 2) r = r | (|m_stk[i]);
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic rst, input logic en, input logic we,
                         input logic [7:0] adr, input logic [7:0] wd, input logic [63:0] ev);
        reset         = rst;
        reg_en        = en;
        write_en      = we;
        address       = adr;
        data_write_in = wd;
        event_in      = ev;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        we;
        logic [7:0]  adr;
        logic [7:0]  wd;
        logic [63:0] ev;
        logic [7:0]  dout;
        logic        rv;
        logic        ae;
        logic        irq;
        int          cidx;
        logic [7:0]  cval;
    } vec_t;

    function automatic vec_t mk(input logic rst, en, we, input logic [7:0] adr, wd,
                                input logic [63:0] ev, input logic [7:0] dout,
                                input logic rv, ae, iq, input int cidx, input logic [7:0] cval);
        vec_t v;
        v.rst = rst; v.en = en; v.we = we; v.adr = adr; v.wd = wd; v.ev = ev;
        v.dout = dout; v.rv = rv; v.ae = ae; v.irq = iq; v.cidx = cidx; v.cval = cval;
        return v;
    endfunction

    localparam logic [63:0] E24  = 64'h0000_0000_0100_0000;
    localparam logic [63:0] E3F0 = 64'h0000_0000_F000_0000;
    localparam logic [63:0] E6FF = 64'h00FF_0000_0000_0000;
    localparam logic [63:0] E7   = 64'h0100_0000_0000_0000;
    localparam logic [7:0]  R2W  = SHADOW ? 8'h34 : 8'h3C;

    vec_t vecs[$];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 64'h0);
        status_in = 64'h0123_4567_89AB_CDEF;

        // Reset state of the whole bank.
        tick();
        tick();
        check("reset_cfg", cfg_out, 64'h0000_0000_0034_1285);
        check("reset_irq", 64'(irq), 64'h0);
        check("reset_rv",  64'(rd_valid), 64'h0);

        //            rst  en   we   adr    wd     ev    dout  rv   ae             irq  idx cval
        vecs.push_back(mk(1'b1,1'b0,1'b0,8'd0, 8'h00,64'h0,8'h00,1'b0,1'b0,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd0, 8'h00,64'h0,8'h85,1'b1,1'b0,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd2, 8'h3C,64'h0,8'h85,1'b0,1'b0,        1'b0,2,R2W));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd2, 8'h00,64'h0,8'h3C,1'b1,1'b0,        1'b0,2,R2W));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'd0, 8'h00,64'h0,8'h3C,1'b0,1'b0,        1'b0,3,8'h00));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'd0, 8'h00,E24,  8'h3C,1'b0,1'b0,        1'b1,3,8'h01));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd3, 8'h00,64'h0,8'h01,1'b1,1'b0,        1'b1,3,8'h01));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd3, 8'h01,E24,  8'h01,1'b0,1'b0,        1'b1,3,8'h01));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd3, 8'h01,64'h0,8'h01,1'b0,1'b0,        1'b0,3,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd3, 8'h00,64'h0,8'h00,1'b1,1'b0,        1'b0,3,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd4, 8'hFF,64'h0,8'h00,1'b0,1'b0,        1'b0,4,8'hFF));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd0, 8'h00,64'h0,8'h85,1'b1,1'b0,        1'b0,4,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd4, 8'h00,64'h0,8'h00,1'b1,1'b0,        1'b0,4,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd0, 8'h00,64'h0,8'h85,1'b1,1'b0,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd13,8'h00,64'h0,8'h00,1'b1,1'b1,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd13,8'hFF,64'h0,8'h00,1'b0,1'b1,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'd0, 8'h00,64'h0,8'h00,1'b0,1'b0,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd5, 8'hFF,64'h0,8'h00,1'b0,1'b0,        1'b0,5,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd5, 8'h00,64'h0,8'h45,1'b1,1'b0,        1'b0,5,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd6, 8'hFF,E6FF, 8'h45,1'b0,1'b0,        1'b0,6,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd6, 8'h00,64'h0,8'h23,1'b1,1'b0,        1'b0,6,8'h00));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd7, 8'hA5,E7,   8'h23,1'b0,1'b0,        1'b0,7,8'hA5));
        vecs.push_back(mk(1'b0,1'b1,1'b0,8'd8, 8'h00,64'h0,8'h00,1'b1,!SHADOW,     1'b0,7,8'h00));
        vecs.push_back(mk(1'b1,1'b1,1'b1,8'd0, 8'h55,64'h0,8'h00,1'b0,1'b0,        1'b0,0,8'h85));
        vecs.push_back(mk(1'b0,1'b0,1'b0,8'd0, 8'h00,E3F0, 8'h00,1'b0,1'b0,        1'b1,3,8'hF0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd3, 8'h30,64'h0,8'h00,1'b0,1'b0,        1'b1,3,8'hC0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,8'd3, 8'hC0,64'h0,8'h00,1'b0,1'b0,        1'b0,3,8'h00));

        foreach (vecs[k]) begin
            drive(vecs[k].rst, vecs[k].en, vecs[k].we, vecs[k].adr, vecs[k].wd, vecs[k].ev);
            tick();
            check($sformatf("row%0d_dout", k), 64'(data_read_out), 64'(vecs[k].dout));
            check($sformatf("row%0d_rv", k),   64'(rd_valid),      64'(vecs[k].rv));
            check($sformatf("row%0d_ae", k),   64'(addr_err),      64'(vecs[k].ae));
            check($sformatf("row%0d_irq", k),  64'(irq),           64'(vecs[k].irq));
            check($sformatf("row%0d_cfg", k),  64'(cfg_out[vecs[k].cidx*8 +: 8]), 64'(vecs[k].cval));
        end

        // RW register path, with and without shadow copies.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 64'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'd1, 8'hAA, 64'h0);
        tick();
        check("rw1_cfg_after_write", 64'(cfg_out[15:8]), SHADOW ? 64'h12 : 64'hAA);
        drive(1'b0, 1'b1, 1'b0, 8'd1, 8'h00, 64'h0);
        tick();
        check("rw1_readback", 64'(data_read_out), 64'hAA);
        check("rw1_readback_rv", 64'(rd_valid), 64'h1);
        drive(1'b0, 1'b1, 1'b1, 8'd8, 8'h01, 64'h0);
        tick();
        check("commit_cfg", 64'(cfg_out[15:8]), 64'hAA);
        check("commit_ae", 64'(addr_err), SHADOW ? 64'h0 : 64'h1);
        drive(1'b0, 1'b1, 1'b1, 8'd1, 8'h77, 64'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 8'd8, 8'h02, 64'h0);
        tick();
        check("commit_bit0_clear", 64'(cfg_out[15:8]), SHADOW ? 64'hAA : 64'h77);

        // Randomized traffic against the model.
        drive(1'b1, 1'b0, 1'b0, 8'd0, 8'h00, 64'h0);
        tick();
        for (int c = 0; c < 3000; c++) begin
            logic [7:0]  adr;
            logic [63:0] ev;
            adr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            ev  = ($urandom_range(0, 3) == 0) ? ({$urandom, $urandom} & {$urandom, $urandom}) : 64'h0;
            status_in = {$urandom, $urandom};
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), adr, 8'($urandom), ev);
            tick();
            check($sformatf("rnd%0d_dout", c), 64'(data_read_out), 64'(m_dout));
            check($sformatf("rnd%0d_rv", c),   64'(rd_valid),      64'(m_rv));
            check($sformatf("rnd%0d_ae", c),   64'(addr_err),      64'(m_ae));
            check($sformatf("rnd%0d_cfg", c),  cfg_out,            exp_cfg());
            check($sformatf("rnd%0d_irq", c),  64'(irq),           64'(exp_irq()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rb_param_bank.md
Name: rb_param_bank

Overview:
Parametrised register bank. It is the successor to the fixed per-block register banks: width, depth, base address and per-register access mode are all set by parameters.
- Supported access modes: RW, RO status, W1C sticky events and self-clearing PULSE.
- Adds a read-valid strobe, an address-error flag and an interrupt output.
- Sits between the SPI/UART register master and a DSP or system block. Hardware fields are flattened into packed vectors.

Parameters:
ADR_BITS, 8, address bus width
DATA_W, 8, register data width
NUM_REGS, 8, number of registers (1..64)
BASE_ADR, 0, address of register 0; register i sits at BASE_ADR+i
RESET_VAL, 0, packed [NUM_REGS*DATA_W-1:0] reset values for RW registers
RO_MASK, 0, [NUM_REGS-1:0]; bit i=1 makes register i read-only status
W1C_MASK, 0, [NUM_REGS-1:0]; bit i=1 makes register i sticky write-1-to-clear
PULSE_MASK, 0, [NUM_REGS-1:0]; bit i=1 makes register i self-clearing pulse

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
address  in  ADR_BITS  register address
data_write_in  in  DATA_W  write data
reg_en  in  1  access strobe, one cycle per access
write_en  in  1  1 = write, 0 = read; qualified by reg_en
data_read_out  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: data_read_out is valid
addr_err  out  1  one-cycle pulse: last access was out of range
cfg_out  out  NUM_REGS*DATA_W  register i drives slice [i*DATA_W +: DATA_W]
status_in  in  NUM_REGS*DATA_W  RO source values; unused slices ignored
event_in  in  NUM_REGS*DATA_W  W1C set pulses; unused slices ignored
irq  out  1  OR of all W1C register bits

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). No asynchronous paths.
- Reset state:
  - RW registers = RESET_VAL.
  - W1C and PULSE registers = 0.
  - data_read_out, rd_valid, addr_err = 0.
  - irq = 0 one cycle after reset is asserted.
- Mode precedence when masks overlap: RO > W1C > PULSE > RW.
- Address decode: in range when BASE_ADR <= address < BASE_ADR+NUM_REGS; idx = address-BASE_ADR.
- Write (reg_en & write_en, in range):
  - RW: register takes data_write_in on the next edge.
  - RO: write ignored.
  - W1C: bits written 1 are cleared.
  - PULSE: register takes data for exactly one cycle, then returns to 0.
  - rd_valid stays 0.
- Read (reg_en & !write_en):
  - data_read_out and rd_valid are updated at the edge after the request; latency 1.
  - Return value: RW = stored value; RO = status_in slice sampled in the request cycle; W1C = sticky value; PULSE = 0.
- Out-of-range access:
  - No state change.
  - addr_err pulses 1 cycle after the request.
  - A read also pulses rd_valid and returns 0.
- data_read_out holds its value when no read is in progress. rd_valid and addr_err are single-cycle pulses.
- W1C registers:
  - Each bit is set when the corresponding event_in bit is high at an edge.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- cfg_out slices:
  - RO slices = 0.
  - W1C slices = sticky value.
  - PULSE slices = pulse value.
- irq is combinational OR over W1C storage, so it is high in the cycle after the first event.
- Back-to-back accesses every cycle are supported. No stall and no backpressure.
- Reset asserted mid-access: the access is dropped; reset values apply on that edge.

Optional Feature:
RB_SHADOW_EN
- Defined:
  - Each RW register has a shadow copy and an active copy.
  - Writes go to the shadow copy; reads return the shadow copy; cfg_out drives the active copy.
  - Commit address = BASE_ADR+NUM_REGS, treated as in range. Writing bit0=1 there copies every shadow to active on the next edge.
  - If a shadow write and a commit occur in the same cycle, the just-written data is committed.
  - Reading the commit address returns 0.
  - Both copies reset to RESET_VAL.
- Undefined:
  - RW registers are a single copy; writes reach cfg_out on the next edge.
  - The commit address is out of range and raises addr_err.

Decomposition:
- Package rb_pkg holds:
  - rb_mode_t enum {RB_RW, RB_RO, RB_W1C, RB_PULSE}
  - a function mode_of(idx) that resolves the masks by precedence
  - localparam RB_MAX_REGS = 64
- One sub-module, rb_sticky_field: DATA_W-wide W1C storage with set-priority. It is instantiated per W1C register inside a generate loop.

Test Plan:
- Reset release with RESET_VAL reg0=8'h85 → cfg_out[7:0]=8'h85; read addr 0 gives data 8'h85 with rd_valid one cycle later; irq=0.
- Write 8'h3C to RW reg 2, then read it → cfg_out[23:16]=8'h3C after one edge; readback 8'h3C; rd_valid exactly 1 cycle.
- W1C reg 3 (W1C_MASK[3]=1):
  - event_in bit 24 pulsed → read returns 8'h01 and irq=1.
  - Write 8'h01 in the same cycle as a new event → bit stays 1.
  - Write 8'h01 with no event → bit 0 and irq=0.
- PULSE reg 4: write 8'hFF → cfg_out[39:32]=8'hFF for exactly one cycle, then 8'h00; read returns 8'h00.
- Read address BASE_ADR+NUM_REGS+5 → data 0, rd_valid=1, addr_err=1 for one cycle; writes there change nothing.
- RB_SHADOW_EN: write 8'hAA to reg 1 → cfg_out unchanged and readback 8'hAA; write 8'h01 to the commit address → cfg_out[15:8]=8'hAA on the next edge.
